// File: rtl/fp16_mul_seq.sv
// Sequential IEEE-754 binary16 multiplier: early special-case resolution, 11-cycle shift-add
// significand multiply, normalise and round-to-nearest-even. Option macro: FP16_MUL_FTZ_EN.
module fp16_mul_seq #(
  parameter logic [15:0] QNAN_PATTERN = 16'h7E00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] result,
  output logic [3:0]  flags
);

  typedef enum logic [2:0] {StIdle, StUnpack, StMul, StRound, StDone} state_e;

  state_e      state_q, state_d;
  logic        in_ready_q;
  logic        out_valid_q, out_valid_d;
  logic [15:0] a_q, a_d, b_q, b_d;
  logic [15:0] result_q, result_d;
  logic [3:0]  flags_q, flags_d;
  logic        sign_q, sign_d;
  logic [6:0]  exp_q, exp_d;  // two's complement biased product exponent
  logic [21:0] acc_q, acc_d;
  logic [21:0] mcand_q, mcand_d;
  logic [10:0] mplier_q, mplier_d;
  logic [3:0]  cnt_q, cnt_d;

  // Operand classification
  logic [4:0]  ea, eb, ea_eff, eb_eff;
  logic [9:0]  fa, fb;
  logic [10:0] sig_a, sig_b;
  logic        a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero;
  logic        sign_ab;
  logic [3:0]  zero_flags;

  assign ea      = a_q[14:10];
  assign eb      = b_q[14:10];
  assign fa      = a_q[9:0];
  assign fb      = b_q[9:0];
  assign sign_ab = a_q[15] ^ b_q[15];

  assign a_nan  = (ea == 5'h1F) && (fa != 10'd0);
  assign b_nan  = (eb == 5'h1F) && (fb != 10'd0);
  assign a_snan = a_nan && !fa[9];
  assign b_snan = b_nan && !fb[9];
  assign a_inf  = (ea == 5'h1F) && (fa == 10'd0);
  assign b_inf  = (eb == 5'h1F) && (fb == 10'd0);

`ifdef FP16_MUL_FTZ_EN
  logic flush_in;
  assign a_zero = (ea == 5'd0);
  assign b_zero = (eb == 5'd0);
  // A flushed subnormal against a nonzero finite operand hides a nonzero product.
  assign flush_in = ((ea == 5'd0) && (fa != 10'd0) && (b_q[14:0] != 15'd0)) ||
                    ((eb == 5'd0) && (fb != 10'd0) && (a_q[14:0] != 15'd0));
  assign zero_flags = {2'b00, flush_in, flush_in};
`else
  assign a_zero = (ea == 5'd0) && (fa == 10'd0);
  assign b_zero = (eb == 5'd0) && (fb == 10'd0);
  assign zero_flags = 4'b0000;
`endif

  assign sig_a  = {(ea != 5'd0), fa};
  assign sig_b  = {(eb != 5'd0), fb};
  assign ea_eff = (ea == 5'd0) ? 5'd1 : ea;
  assign eb_eff = (eb == 5'd0) ? 5'd1 : eb;

  function automatic logic [4:0] lzc22(input logic [21:0] v);
    logic [4:0] n;
    n = 5'd0;
    for (int i = 0; i < 22; i++) begin
      if (v[i]) n = 5'(21 - i);
    end
    return n;
  endfunction

  // Normalise / round datapath
  logic [4:0]        lz, sh;
  logic [21:0]       norm;
  logic signed [8:0] e_norm, e_rnd, sh_full;
  logic [43:0]       wide;
  logic [10:0]       mant;
  logic [11:0]       mant_r;
  logic              guard, sticky, round_up, tiny, inexact;
  logic [15:0]       round_res;
  logic [3:0]        round_flags;

  always_comb begin
    lz      = lzc22(acc_q);
    norm    = acc_q << lz;
    // norm[21] is the hidden bit; value = norm/2^21 * 2^(e_norm-15)
    e_norm  = $signed({{2{exp_q[6]}}, exp_q}) + 9'sd1 - $signed({4'd0, lz});
    tiny    = (e_norm < 9'sd1);
    sh_full = 9'sd1 - e_norm;
    if (!tiny) begin
      sh = 5'd0;
    end else if (sh_full > 9'sd22) begin
      sh = 5'd22;
    end else begin
      sh = sh_full[4:0];
    end
    wide     = {norm, 22'd0} >> sh;
    mant     = wide[43:33];
    guard    = wide[32];
    sticky   = |wide[31:0];
    round_up = guard && (sticky || mant[0]);
    mant_r   = {1'b0, mant} + {11'd0, round_up};
    inexact  = guard || sticky;
    e_rnd    = e_norm + $signed({8'd0, mant_r[11]});

    round_res   = 16'h0000;
    round_flags = 4'b0000;
    if (tiny) begin
`ifdef FP16_MUL_FTZ_EN
      round_res   = {sign_q, 15'd0};
      round_flags = 4'b0011;
`else
      // A carry into bit 10 lands in the exponent field, giving the smallest normal.
      round_res   = {sign_q, 4'd0, mant_r[10:0]};
      round_flags = {2'b00, inexact, inexact};
`endif
    end else if (e_rnd > 9'sd30) begin
      round_res   = {sign_q, 15'h7C00};
      round_flags = 4'b0101;
    end else begin
      round_res   = {sign_q, e_rnd[4:0], mant_r[11] ? 10'd0 : mant_r[9:0]};
      round_flags = {3'b000, inexact};
    end
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    flags_d     = flags_q;
    sign_d      = sign_q;
    exp_d       = exp_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    cnt_d       = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid && in_ready_q) begin
          a_d     = a;
          b_d     = b;
          state_d = StUnpack;
        end
      end
      StUnpack: begin
        sign_d  = sign_ab;
        state_d = StDone;
        if (a_nan || b_nan) begin
          result_d = QNAN_PATTERN;
          flags_d  = {a_snan || b_snan, 3'b000};
        end else if ((a_inf && b_zero) || (a_zero && b_inf)) begin
          result_d = QNAN_PATTERN;
          flags_d  = 4'b1000;
        end else if (a_inf || b_inf) begin
          result_d = {sign_ab, 15'h7C00};
          flags_d  = 4'b0000;
        end else if (a_zero || b_zero) begin
          result_d = {sign_ab, 15'h0000};
          flags_d  = zero_flags;
        end else begin
          exp_d    = {2'b00, ea_eff} + {2'b00, eb_eff} - 7'd15;
          acc_d    = 22'd0;
          mcand_d  = {11'd0, sig_a};
          mplier_d = sig_b;
          cnt_d    = 4'd10;
          state_d  = StMul;
        end
      end
      StMul: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - 4'd1;
        if (cnt_q == 4'd0) state_d = StRound;
      end
      StRound: begin
        result_d = round_res;
        flags_d  = round_flags;
        state_d  = StDone;
      end
      StDone: begin
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      a_q         <= 16'd0;
      b_q         <= 16'd0;
      result_q    <= 16'd0;
      flags_q     <= 4'd0;
      sign_q      <= 1'b0;
      exp_q       <= 7'd0;
      acc_q       <= 22'd0;
      mcand_q     <= 22'd0;
      mplier_q    <= 11'd0;
      cnt_q       <= 4'd0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d == StIdle);
      out_valid_q <= out_valid_d;
      a_q         <= a_d;
      b_q         <= b_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
      sign_q      <= sign_d;
      exp_q       <= exp_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      cnt_q       <= cnt_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_fp16_mul_seq.sv
// Directed self-checking bench for fp16_mul_seq: specials, rounding, underflow, backpressure,
// reset mid-operation.
module tb_fp16_mul_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] a = 16'h0000;
  logic [15:0] b = 16'h0000;
  logic        in_ready, out_valid;
  logic [15:0] result;
  logic [3:0]  flags;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  fp16_mul_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .flags    (flags)
  );

  // Issue one operation and wait (bounded) for out_valid; leaves the result unconsumed.
  task automatic run_op(input logic [15:0] op_a, input logic [15:0] op_b,
                        output logic [15:0] res, output logic [3:0] flg, output int lat);
    int n;
    @(negedge clk);
    a = op_a;
    b = op_b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = 16'hDEAD;
    b = 16'hBEEF;
    lat = 0;
    while (!out_valid && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid) begin
      tests_run++;
      tests_failed++;
      $display("FAIL timeout %h*%h: out_valid never rose, wanted within 60 cycles", op_a, op_b);
    end
    res = result;
    flg = flags;
  endtask

  task automatic drain;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    #12;
    tests_run++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_hs in_ready=%b out_valid=%b want 0 0", in_ready, out_valid);
    end
    tests_run++;
    if (result !== 16'h0000 || flags !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_data result=%h flags=%b want 0000 0000", result, flags);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_release in_ready=%b want 1", in_ready);
    end
  endtask

  task automatic test_basic;
    logic [15:0] r;
    logic [3:0]  f;
    int          lat;
    run_op(16'h3C00, 16'h3C00, r, f, lat);
    tests_run++;
    if (r !== 16'h3C00 || f !== 4'b0000) begin
      tests_failed++;
      $display("FAIL one_x_one got %h/%b want 3c00/0000", r, f);
    end
    tests_run++;
    if (lat !== 14) begin
      tests_failed++;
      $display("FAIL one_x_one_latency got %0d want 14", lat);
    end
    drain();
  endtask

  task automatic test_backpressure;
    logic [15:0] r;
    logic [3:0]  f;
    int          lat;
    run_op(16'h4000, 16'hC200, r, f, lat);
    tests_run++;
    if (r !== 16'hC600 || f !== 4'b0000) begin
      tests_failed++;
      $display("FAIL two_x_m3 got %h/%b want c600/0000", r, f);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      tests_run++;
      if (result !== 16'hC600 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL hold_%0d result=%h out_valid=%b in_ready=%b want c600 1 0",
                 i, result, out_valid, in_ready);
      end
    end
    drain();
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL handshake out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_overflow;
    logic [15:0] r;
    logic [3:0]  f;
    int          lat;
    run_op(16'h7BFF, 16'h7BFF, r, f, lat);
    tests_run++;
    if (r !== 16'h7C00 || f !== 4'b0101) begin
      tests_failed++;
      $display("FAIL overflow got %h/%b want 7c00/0101", r, f);
    end
    drain();
  endtask

  task automatic test_special;
    logic [15:0] va[6], vb[6], vr[6];
    logic [3:0]  vf[6];
    logic [15:0] r;
    logic [3:0]  f;
    int          lat;
    va = '{16'h7C00, 16'h7D00, 16'h7E00, 16'hFC00, 16'h8000, 16'h0000};
    vb = '{16'h0000, 16'h3C00, 16'h7C00, 16'h4000, 16'h4000, 16'hFC00};
    vr = '{16'h7E00, 16'h7E00, 16'h7E00, 16'hFC00, 16'h8000, 16'h7E00};
    vf = '{4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b1000};
    for (int i = 0; i < 6; i++) begin
      run_op(va[i], vb[i], r, f, lat);
      tests_run++;
      if (r !== vr[i] || f !== vf[i] || lat !== 2) begin
        tests_failed++;
        $display("FAIL special %h*%h got %h/%b lat %0d want %h/%b lat 2",
                 va[i], vb[i], r, f, lat, vr[i], vf[i]);
      end
      drain();
    end
  endtask

  task automatic test_subnormal;
    logic [15:0] va[5], vb[5], vr[5];
    logic [3:0]  vf[5];
    logic [15:0] r;
    logic [3:0]  f;
    int          lat;
    va = '{16'h0001, 16'h0001, 16'h0400, 16'h03FF, 16'h8001};
    vb = '{16'h3800, 16'h3C00, 16'h3800, 16'h3C01, 16'h3C00};
`ifdef FP16_MUL_FTZ_EN
    vr = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h8000};
    vf = '{4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0011};
`else
    vr = '{16'h0000, 16'h0001, 16'h0200, 16'h0400, 16'h8001};
    vf = '{4'b0011, 4'b0000, 4'b0000, 4'b0011, 4'b0000};
`endif
    for (int i = 0; i < 5; i++) begin
      run_op(va[i], vb[i], r, f, lat);
      tests_run++;
      if (r !== vr[i] || f !== vf[i]) begin
        tests_failed++;
        $display("FAIL subnormal %h*%h got %h/%b want %h/%b", va[i], vb[i], r, f, vr[i], vf[i]);
      end
      drain();
    end
  endtask

  task automatic test_rounding;
    logic [15:0] va[3], vb[3], vr[3];
    logic [3:0]  vf[3];
    logic [15:0] r;
    logic [3:0]  f;
    int          lat;
    va = '{16'h3C01, 16'h3E00, 16'h3C01};
    vb = '{16'h3C01, 16'h3E00, 16'h3E00};
    vr = '{16'h3C02, 16'h4080, 16'h3E02};
    vf = '{4'b0001, 4'b0000, 4'b0001};
    for (int i = 0; i < 3; i++) begin
      run_op(va[i], vb[i], r, f, lat);
      tests_run++;
      if (r !== vr[i] || f !== vf[i] || lat !== 14) begin
        tests_failed++;
        $display("FAIL rounding %h*%h got %h/%b lat %0d want %h/%b lat 14",
                 va[i], vb[i], r, f, lat, vr[i], vf[i]);
      end
      drain();
    end
  endtask

  task automatic test_reset_mid_op;
    logic [15:0] r;
    logic [3:0]  f;
    int          lat;
    int          seen;
    @(negedge clk);
    a = 16'h3C00;
    b = 16'h4200;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || result !== 16'h0000 || flags !== 4'b0000 || in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL midop_reset out_valid=%b result=%h flags=%b in_ready=%b want 0 0000 0000 0",
               out_valid, result, flags, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL midop_release in_ready=%b want 1", in_ready);
    end
    seen = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    tests_run++;
    if (seen !== 0) begin
      tests_failed++;
      $display("FAIL stale_output out_valid high %0d cycles want 0", seen);
    end
    run_op(16'h3C00, 16'h4000, r, f, lat);
    tests_run++;
    if (r !== 16'h4000 || f !== 4'b0000 || lat !== 14) begin
      tests_failed++;
      $display("FAIL fresh_op got %h/%b lat %0d want 4000/0000 lat 14", r, f, lat);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_overflow();
    test_special();
    test_subnormal();
    test_rounding();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
